// File: rtl/maze_player_move.sv
// Purpose : player-movement stage of the maze game (wall collision, key auto-repeat, goal detection).
// Latency : a move attempt registers the new cell and the moving pulse on the next clk edge.
// Backpressure: none; the key inputs are level-held and sampled every cycle, with no handshake.
//
// Ports:
//   clk, rst_sys            clock, asynchronous active-low reset
//   play_en, restart        game-state enable and one-cycle restart pulse
//   up, down, left, right   held direction keys (already synchronous to clk)
//   map, size               wall map (bit y*GRID+x, 1 = wall) and active maze side N
//   pos_x, pos_y            current player cell
//   step_count              successful moves since the last restart (saturating)
//   win                     high while the player sits on the goal in WIN
//   moving                  one-cycle pulse, coincident with the updated position
//
// Build option: define MAZE_WRAP_EN to make moves off an edge wrap to the opposite edge.
// The wrapped target cell is still wall-checked. Without the macro, edge moves are blocked.

module maze_player_move #(
    parameter int GRID     = 19,
    parameter int STEP_DIV = 50_000_000,
    parameter int CNT_W    = 10
) (
    input  logic                   clk,
    input  logic                   rst_sys,
    input  logic                   play_en,
    input  logic                   restart,
    input  logic                   up,
    input  logic                   down,
    input  logic                   left,
    input  logic                   right,
    input  logic [GRID*GRID-1:0]   map,
    input  logic [4:0]             size,
    output logic [4:0]             pos_x,
    output logic [4:0]             pos_y,
    output logic [CNT_W-1:0]       step_count,
    output logic                   win,
    output logic                   moving
);

    localparam int               TMR_W    = $clog2(STEP_DIV);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(STEP_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [4:0]       HOME     = 5'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_WIN  = 2'd2
    } state_t;

    state_t             state, state_nx;
    logic [4:0]         pos_x_nx, pos_y_nx;
    logic [CNT_W-1:0]   cnt_nx;
    logic               moving_nx;
    logic [TMR_W-1:0]   timer, timer_nx;
    logic               key_prev, key_prev_nx;

    logic               any_key;
    logic               attempt;
    logic               at_goal;
    logic signed [6:0]  dx, dy;
    logic signed [6:0]  tx_raw, ty_raw;
    logic signed [6:0]  tx, ty;
    logic signed [6:0]  n_s;
    logic               in_range;
    logic [8:0]         idx;
    logic               target_open;

    assign any_key = up | down | left | right;

    // First cycle of a press always attempts; while held, the timer wrapping
    // back to zero marks the next slot. Blocked attempts use up the slot too.
    assign attempt = any_key && (!key_prev || (timer == '0));

    assign at_goal = (pos_x == size - 5'd2) && (pos_y == size - 5'd2);

    // Direction priority: up > down > left > right.
    always_comb begin
        dx = '0;
        dy = '0;
        if (up) begin
            dy = -7'sd1;
        end else if (down) begin
            dy = 7'sd1;
        end else if (left) begin
            dx = -7'sd1;
        end else if (right) begin
            dx = 7'sd1;
        end
    end

    // Targets are widened to signed 7 bits so that stepping left/up from 0
    // goes to -1 rather than wrapping to 31.
    assign n_s    = $signed({2'b00, size});
    assign tx_raw = $signed({2'b00, pos_x}) + dx;
    assign ty_raw = $signed({2'b00, pos_y}) + dy;

`ifdef MAZE_WRAP_EN
    always_comb begin
        tx = tx_raw;
        ty = ty_raw;
        if (tx_raw[6]) begin
            tx = n_s - 7'sd1;
        end else if (tx_raw >= n_s) begin
            tx = '0;
        end
        if (ty_raw[6]) begin
            ty = n_s - 7'sd1;
        end else if (ty_raw >= n_s) begin
            ty = '0;
        end
    end
`else
    assign tx = tx_raw;
    assign ty = ty_raw;
`endif

    assign in_range = !tx[6] && (tx < n_s) && !ty[6] && (ty < n_s);

    // Only in-range targets are looked up, so the index never exceeds 360.
    assign idx         = 9'(ty[4:0]) * 9'(GRID) + 9'(tx[4:0]);
    assign target_open = in_range && !map[idx];

    assign win = (state == ST_WIN);

    always_comb begin
        state_nx    = state;
        pos_x_nx    = pos_x;
        pos_y_nx    = pos_y;
        cnt_nx      = step_count;
        moving_nx   = 1'b0;
        timer_nx    = '0;
        key_prev_nx = 1'b0;

        case (state)
            ST_IDLE: begin
                pos_x_nx = HOME;
                pos_y_nx = HOME;
                if (restart) begin
                    cnt_nx = '0;
                end else if (play_en) begin
                    state_nx = ST_PLAY;
                end
            end

            ST_PLAY: begin
                if (restart) begin
                    state_nx = ST_IDLE;
                    pos_x_nx = HOME;
                    pos_y_nx = HOME;
                    cnt_nx   = '0;
                end else if (!play_en) begin
                    state_nx = ST_IDLE;
                    pos_x_nx = HOME;
                    pos_y_nx = HOME;
                end else if (at_goal) begin
                    // Goal is checked on the registered position, so WIN
                    // follows the cycle after the move that reached it.
                    state_nx = ST_WIN;
                end else begin
                    key_prev_nx = any_key;
                    if (any_key) begin
                        timer_nx = (timer == TMR_LAST) ? '0 : timer + TMR_W'(1);
                    end
                    if (attempt && target_open) begin
                        pos_x_nx  = tx[4:0];
                        pos_y_nx  = ty[4:0];
                        moving_nx = 1'b1;
                        if (step_count != CNT_MAX) begin
                            cnt_nx = step_count + CNT_W'(1);
                        end
                    end
                end
            end

            ST_WIN: begin
                if (restart || !play_en) begin
                    state_nx = ST_IDLE;
                    pos_x_nx = HOME;
                    pos_y_nx = HOME;
                    if (restart) begin
                        cnt_nx = '0;
                    end
                end
            end

            default: begin
                state_nx = ST_IDLE;
                pos_x_nx = HOME;
                pos_y_nx = HOME;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_sys) begin
        if (!rst_sys) begin
            state      <= ST_IDLE;
            pos_x      <= HOME;
            pos_y      <= HOME;
            step_count <= '0;
            moving     <= 1'b0;
            timer      <= '0;
            key_prev   <= 1'b0;
        end else begin
            state      <= state_nx;
            pos_x      <= pos_x_nx;
            pos_y      <= pos_y_nx;
            step_count <= cnt_nx;
            moving     <= moving_nx;
            timer      <= timer_nx;
            key_prev   <= key_prev_nx;
        end
    end

endmodule

// File: tb/tb_maze_player_move.sv
module tb_maze_player_move;

    localparam int GRID     = 19;
    localparam int STEP_DIV = 4;
    localparam int CNT_W    = 3;
    localparam int N        = 5;

    logic             clk = 1'b0;
    logic             rst_sys;
    logic             play_en, restart, up, down, left, right;
    logic [360:0]     map;
    logic [4:0]       size;
    logic [4:0]       pos_x, pos_y;
    logic [CNT_W-1:0] step_count;
    logic             win, moving;

    always #5 clk = ~clk;

    maze_player_move #(
        .GRID     (GRID),
        .STEP_DIV (STEP_DIV),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_sys    (rst_sys),
        .play_en    (play_en),
        .restart    (restart),
        .up         (up),
        .down       (down),
        .left       (left),
        .right      (right),
        .map        (map),
        .size       (size),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .step_count (step_count),
        .win        (win),
        .moving     (moving)
    );

    int checks = 0;
    int errors = 0;
    int mv_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Game mode: 0 idle, 1 playing, 2 won. held counts cycles a key has been
    // held during play; an attempt falls on every multiple of STEP_DIV.
    int m_mode   = 0;
    int m_px     = 1;
    int m_py     = 1;
    int m_cnt    = 0;
    int m_moving = 0;
    int m_held   = 0;
    int m_tx, m_ty;

    always @(posedge clk or negedge rst_sys) begin
        if (!rst_sys) begin
            m_mode = 0; m_px = 1; m_py = 1; m_cnt = 0; m_moving = 0; m_held = 0;
        end else begin
            m_moving = 0;
            if (m_mode == 0) begin
                m_px = 1; m_py = 1; m_held = 0;
                if (restart) m_cnt = 0;
                else if (play_en) m_mode = 1;
            end else if (m_mode == 2) begin
                if (restart || !play_en) begin
                    m_mode = 0; m_px = 1; m_py = 1;
                    if (restart) m_cnt = 0;
                end
            end else begin
                if (restart) begin
                    m_mode = 0; m_px = 1; m_py = 1; m_cnt = 0; m_held = 0;
                end else if (!play_en) begin
                    m_mode = 0; m_px = 1; m_py = 1; m_held = 0;
                end else if (m_px == int'(size) - 2 && m_py == int'(size) - 2) begin
                    m_mode = 2; m_held = 0;
                end else if (up || down || left || right) begin
                    if (m_held % STEP_DIV == 0) begin
                        m_tx = m_px; m_ty = m_py;
                        if (up) m_ty = m_py - 1;
                        else if (down) m_ty = m_py + 1;
                        else if (left) m_tx = m_px - 1;
                        else m_tx = m_px + 1;
`ifdef MAZE_WRAP_EN
                        if (m_tx < 0) m_tx = int'(size) - 1;
                        else if (m_tx >= int'(size)) m_tx = 0;
                        if (m_ty < 0) m_ty = int'(size) - 1;
                        else if (m_ty >= int'(size)) m_ty = 0;
`endif
                        if (m_tx >= 0 && m_tx < int'(size) && m_ty >= 0 && m_ty < int'(size)
                            && map[m_ty * GRID + m_tx] == 1'b0) begin
                            m_px = m_tx; m_py = m_ty; m_moving = 1;
                            if (m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
                        end
                    end
                    m_held = m_held + 1;
                end else begin
                    m_held = 0;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        chk("pos_x", 32'(pos_x), 32'(m_px));
        chk("pos_y", 32'(pos_y), 32'(m_py));
        chk("step_count", 32'(step_count), 32'(m_cnt));
        chk("win", 32'(win), (m_mode == 2) ? 32'd1 : 32'd0);
        chk("moving", 32'(moving), 32'(m_moving));
        if (moving === 1'b1) mv_cnt++;
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // keys = {up, down, left, right}; hold for n edges, then one released edge.
    task automatic press(input logic [3:0] keys, input int n);
        {up, down, left, right} = keys;
        cyc(n);
        {up, down, left, right} = 4'b0000;
        cyc(1);
    endtask

    task automatic go_home();
        play_en = 1'b0;
        cyc(1);
        play_en = 1'b1;
        cyc(1);
    endtask

    initial begin
        rst_sys = 1'b1;
        play_en = 1'b0; restart = 1'b0;
        up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
        size = 5'(N);
        // 5x5 maze: border walls, open interior, plus a few open border
        // cells for the edge tests. Bits outside the N x N area stay 0 so
        // that only the range check can block a move beyond x = N-1.
        map = '0;
        for (int y = 0; y < N; y++)
            for (int x = 0; x < N; x++)
                if (x == 0 || y == 0 || x == N - 1 || y == N - 1) map[y * GRID + x] = 1'b1;
        map[1 * GRID + 0] = 1'b0;   // (0,1)
        map[2 * GRID + 0] = 1'b0;   // (0,2)
        map[2 * GRID + 4] = 1'b0;   // (4,2)
        map[0 * GRID + 2] = 1'b0;   // (2,0)

        #2 rst_sys = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_sys = 1'b1;
        chk("reset_pos_x", 32'(pos_x), 32'd1);
        chk("reset_pos_y", 32'(pos_y), 32'd1);
        chk("reset_count", 32'(step_count), 32'd0);
        chk("reset_win", 32'(win), 32'd0);

        // Enter play, take one step, then reset asynchronously mid-cycle.
        play_en = 1'b1;
        cyc(1);
        press(4'b0001, 1);
        chk("first_step_x", 32'(pos_x), 32'd2);
        chk("first_step_cnt", 32'(step_count), 32'd1);
        rst_sys = 1'b0;
        #1;
        chk("async_rst_x", 32'(pos_x), 32'd1);
        chk("async_rst_cnt", 32'(step_count), 32'd0);
        chk("async_rst_win", 32'(win), 32'd0);
        cyc(1);
        rst_sys = 1'b1;
        cyc(1);

        // Hold right 9 cycles: attempts at 0, 4, 8; third hits wall at x=4.
        mv_cnt = 0;
        right = 1'b1;
        cyc(9);
        right = 1'b0;
        chk("repeat_x", 32'(pos_x), 32'd3);
        chk("repeat_cnt", 32'(step_count), 32'd2);
        chk("repeat_pulses", 32'(mv_cnt), 32'd2);
        cyc(1);

        // Up into the wall at (3,0).
        mv_cnt = 0;
        press(4'b1000, 1);
        chk("wall_y", 32'(pos_y), 32'd1);
        chk("wall_cnt", 32'(step_count), 32'd2);
        chk("wall_pulses", 32'(mv_cnt), 32'd0);

        // up+left: up wins and is blocked on every repeat slot.
        press(4'b1010, 6);
        chk("prio_x", 32'(pos_x), 32'd3);
        chk("prio_y", 32'(pos_y), 32'd1);

        press(4'b0111, 1);  // down beats left/right -> (3,2)
        chk("prio_down_y", 32'(pos_y), 32'd2);
        press(4'b0011, 1);  // left beats right -> (2,2)
        chk("prio_left_x", 32'(pos_x), 32'd2);
        press(4'b0001, 1);  // -> (3,2)

        // Step onto the goal (3,3): win follows one cycle later.
        down = 1'b1;
        cyc(1);
        down = 1'b0;
        chk("goal_y", 32'(pos_y), 32'd3);
        chk("goal_win_early", 32'(win), 32'd0);
        cyc(1);
        chk("goal_win", 32'(win), 32'd1);
        chk("goal_cnt", 32'(step_count), 32'd6);
        press(4'b0010, 3);
        chk("win_frozen_x", 32'(pos_x), 32'd3);
        restart = 1'b1;
        cyc(1);
        restart = 1'b0;
        chk("restart_x", 32'(pos_x), 32'd1);
        chk("restart_win", 32'(win), 32'd0);
        chk("restart_cnt", 32'(step_count), 32'd0);
        cyc(1);

        // Saturation of the 3-bit counter, then play_en drop keeps the count.
        for (int i = 0; i < 5; i++) begin
            press(4'b0001, 1);
            press(4'b0010, 1);
        end
        press(4'b0001, 1);
        chk("sat_cnt", 32'(step_count), 32'd7);
        play_en = 1'b0;
        cyc(1);
        chk("drop_x", 32'(pos_x), 32'd1);
        chk("drop_cnt", 32'(step_count), 32'd7);
        play_en = 1'b1;
        cyc(1);
        restart = 1'b1;
        cyc(1);
        restart = 1'b0;
        chk("play_restart_cnt", 32'(step_count), 32'd0);
        cyc(1);

        // Goal move coinciding with play_en falling -> idle, no win.
        press(4'b0001, 1);
        press(4'b0001, 1);
        press(4'b0100, 1);
        down = 1'b1; play_en = 1'b0;
        cyc(1);
        down = 1'b0;
        chk("drop_goal_y", 32'(pos_y), 32'd1);
        cyc(1);
        chk("drop_goal_win", 32'(win), 32'd0);
        play_en = 1'b1;
        cyc(1);

        // Left edge at (0,2).
        press(4'b0010, 1);
        press(4'b0100, 1);
        press(4'b0010, 1);
`ifdef MAZE_WRAP_EN
        chk("edge_left_x", 32'(pos_x), 32'd4);
`else
        chk("edge_left_x", 32'(pos_x), 32'd0);
`endif
        chk("edge_left_y", 32'(pos_y), 32'd2);
        go_home();

        // Right edge at (4,2); (5,2) is 0 in the map, so only range blocks it.
        press(4'b0100, 1);
        for (int i = 0; i < 3; i++) press(4'b0001, 1);
        chk("edge_reach_x", 32'(pos_x), 32'd4);
        press(4'b0001, 1);
`ifdef MAZE_WRAP_EN
        chk("edge_right_x", 32'(pos_x), 32'd0);
`else
        chk("edge_right_x", 32'(pos_x), 32'd4);
`endif
        go_home();

        // Top edge at (2,0): blocked by range, or wrapped onto the wall (2,4).
        press(4'b0001, 1);
        press(4'b1000, 1);
        press(4'b1000, 1);
        chk("edge_top_x", 32'(pos_x), 32'd2);
        chk("edge_top_y", 32'(pos_y), 32'd0);

        cyc(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
